dmem_arbiter: RTL and testbench

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arbiter.sv | 171 +++++++++++++++++
 tb/tb_dmem_arbiter.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Shares one data-memory port between the master and slave pipes, master first.
// Each access waits for mem_ack or aborts after TIMEOUT wait cycles (sticky flag).
module dmem_arbiter #(
  parameter logic [7:0] TIMEOUT = 8'd255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m_req,
  input  logic        m_we,
  input  logic [31:0] m_addr,
  input  logic [31:0] m_wdata,
  output logic [31:0] m_rdata,
  input  logic        s_req,
  input  logic        s_we,
  input  logic [31:0] s_addr,
  input  logic [31:0] s_wdata,
  output logic [31:0] s_rdata,
  output logic        stallM,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        timeout
);

  // state  | meaning
  // IDLE   | no access in flight, latching new requests
  // M_ACC  | master access on the memory port
  // S_ACC  | slave access on the memory port
  // DONE   | one-cycle release of the stall
  typedef enum logic [1:0] {IDLE = 2'd0, M_ACC = 2'd1, S_ACC = 2'd2, DONE = 2'd3} state_t;

  state_t      state_q, state_d;
  logic        pend_q, pend_d;
  logic        m_we_q, m_we_d;
  logic [31:0] m_addr_q, m_addr_d;
  logic [31:0] m_wdata_q, m_wdata_d;
  logic        s_we_q, s_we_d;
  logic [31:0] s_addr_q, s_addr_d;
  logic [31:0] s_wdata_q, s_wdata_d;
  logic [7:0]  wait_q, wait_d;
  logic [31:0] m_rdata_q, m_rdata_d;
  logic [31:0] s_rdata_q, s_rdata_d;
  logic        timeout_q, timeout_d;

  logic in_acc, expired, finish;

  assign in_acc  = (state_q == M_ACC) || (state_q == S_ACC);
  assign expired = (wait_q == TIMEOUT);
  assign finish  = in_acc && (mem_ack || expired);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (m_req)      state_d = M_ACC;
        else if (s_req) state_d = S_ACC;
      end
      M_ACC: if (finish) state_d = pend_q ? S_ACC : DONE;
      S_ACC: if (finish) state_d = DONE;
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    stallM    = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = 32'd0;
    mem_wdata = 32'd0;
    case (state_q)
      IDLE: stallM = m_req | s_req;
      M_ACC: begin
        stallM    = 1'b1;
        mem_req   = 1'b1;
        mem_we    = m_we_q;
        mem_addr  = m_addr_q;
        mem_wdata = m_wdata_q;
      end
      S_ACC: begin
        stallM    = 1'b1;
        mem_req   = 1'b1;
        mem_we    = s_we_q;
        mem_addr  = s_addr_q;
        mem_wdata = s_wdata_q;
      end
      default: ;
    endcase
  end

  // Datapath next-state: request latches, wait counter, load capture, sticky abort flag.
  always_comb begin
    pend_d    = pend_q;
    m_we_d    = m_we_q;
    m_addr_d  = m_addr_q;
    m_wdata_d = m_wdata_q;
    s_we_d    = s_we_q;
    s_addr_d  = s_addr_q;
    s_wdata_d = s_wdata_q;
    wait_d    = wait_q;
    m_rdata_d = m_rdata_q;
    s_rdata_d = s_rdata_q;
    timeout_d = timeout_q;

    if (state_q == IDLE) begin
      wait_d = 8'd0;
      if (m_req) begin
        m_we_d    = m_we;
        m_addr_d  = m_addr;
        m_wdata_d = m_wdata;
        pend_d    = s_req;
      end
      if (s_req) begin
        s_we_d    = s_we;
        s_addr_d  = s_addr;
        s_wdata_d = s_wdata;
      end
    end

    if (in_acc) begin
      if (finish) wait_d = 8'd0;
      else        wait_d = wait_q + 8'd1;
      if (finish && !mem_ack) timeout_d = 1'b1;
    end

    if (state_q == M_ACC && mem_ack && !m_we_q) m_rdata_d = mem_rdata;
    if (state_q == S_ACC && mem_ack && !s_we_q) s_rdata_d = mem_rdata;
    if (state_q == S_ACC && finish) pend_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend_q    <= 1'b0;
      m_we_q    <= 1'b0;
      m_addr_q  <= 32'd0;
      m_wdata_q <= 32'd0;
      s_we_q    <= 1'b0;
      s_addr_q  <= 32'd0;
      s_wdata_q <= 32'd0;
      wait_q    <= 8'd0;
      m_rdata_q <= 32'd0;
      s_rdata_q <= 32'd0;
      timeout_q <= 1'b0;
    end else begin
      pend_q    <= pend_d;
      m_we_q    <= m_we_d;
      m_addr_q  <= m_addr_d;
      m_wdata_q <= m_wdata_d;
      s_we_q    <= s_we_d;
      s_addr_q  <= s_addr_d;
      s_wdata_q <= s_wdata_d;
      wait_q    <= wait_d;
      m_rdata_q <= m_rdata_d;
      s_rdata_q <= s_rdata_d;
      timeout_q <= timeout_d;
    end
  end

  assign m_rdata = m_rdata_q;
  assign s_rdata = s_rdata_q;
  assign timeout = timeout_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: reset, master load, dual access, slave wait
// states, timeout abort and reset in the middle of a slave access.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        m_req = 1'b0, m_we = 1'b0;
  logic [31:0] m_addr = 32'd0, m_wdata = 32'd0, m_rdata;
  logic        s_req = 1'b0, s_we = 1'b0;
  logic [31:0] s_addr = 32'd0, s_wdata = 32'd0, s_rdata;
  logic        stallM, mem_req, mem_we, mem_ack = 1'b0, timeout;
  logic [31:0] mem_addr, mem_wdata, mem_rdata = 32'd0;

  int passed = 0;
  int total  = 0;

  dmem_arbiter dut (
    .clk(clk), .rst(rst),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata),
    .s_req(s_req), .s_we(s_we), .s_addr(s_addr), .s_wdata(s_wdata), .s_rdata(s_rdata),
    .stallM(stallM), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack), .timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #12 rst = 1'b1;
    step();
    total++; if (mem_req !== 1'b0) $display("FAIL reset_mem_req got=%0h exp=0", mem_req); else passed++;
    total++; if (stallM !== 1'b0) $display("FAIL reset_stall got=%0h exp=0", stallM); else passed++;
    total++; if ({m_rdata, s_rdata} !== 64'd0) $display("FAIL reset_rdata got=%0h exp=0", {m_rdata, s_rdata}); else passed++;
    total++; if ({timeout, mem_we, mem_addr, mem_wdata} !== 65'd0) $display("FAIL reset_mem_bus got=%0h exp=0", {timeout, mem_we, mem_addr, mem_wdata}); else passed++;
  endtask

  task automatic test_master_load();
    int stalls = 0;
    m_req = 1'b1; m_we = 1'b0; m_addr = 32'h10; #1;
    total++; if (stallM !== 1'b1) $display("FAIL ml_idle_stall got=%0h exp=1", stallM); else passed++;
    if (stallM) stalls++;
    step();
    m_req = 1'b0; m_addr = 32'h0;
    total++; if (mem_req !== 1'b1 || mem_addr !== 32'h10 || mem_we !== 1'b0) $display("FAIL ml_macc got=%0h/%0h/%0h exp=1/10/0", mem_req, mem_addr, mem_we); else passed++;
    if (stallM) stalls++;
    mem_ack = 1'b1; mem_rdata = 32'hDEADBEEF;
    step();
    mem_ack = 1'b0; mem_rdata = 32'h0;
    total++; if (stallM !== 1'b0 || mem_req !== 1'b0 || mem_addr !== 32'h0) $display("FAIL ml_done got=%0h/%0h/%0h exp=0/0/0", stallM, mem_req, mem_addr); else passed++;
    total++; if (m_rdata !== 32'hDEADBEEF) $display("FAIL ml_rdata got=%0h exp=deadbeef", m_rdata); else passed++;
    total++; if (stalls != 2) $display("FAIL ml_stall_cycles got=%0d exp=2", stalls); else passed++;
    step();
  endtask

  task automatic test_dual();
    int stalls = 0;
    m_req = 1'b1; m_we = 1'b1; m_addr = 32'h20; m_wdata = 32'h11111111;
    s_req = 1'b1; s_we = 1'b0; s_addr = 32'h20; s_wdata = 32'h55;
    #1; if (stallM) stalls++;
    step();
    m_req = 1'b0; s_req = 1'b0; m_addr = 32'hFFFF; s_addr = 32'hEEEE; m_wdata = 32'h0; s_wdata = 32'h0;
    if (stallM) stalls++;
    total++; if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'h20 || mem_wdata !== 32'h11111111)
      $display("FAIL dual_master got=%0h/%0h/%0h/%0h exp=1/1/20/11111111", mem_req, mem_we, mem_addr, mem_wdata); else passed++;
    mem_ack = 1'b1; mem_rdata = 32'hAAAA0000;
    step();
    mem_rdata = 32'h12345678;
    if (stallM) stalls++;
    total++; if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 32'h20 || mem_wdata !== 32'h55)
      $display("FAIL dual_slave got=%0h/%0h/%0h/%0h exp=1/0/20/55", mem_req, mem_we, mem_addr, mem_wdata); else passed++;
    total++; if (m_rdata !== 32'hDEADBEEF) $display("FAIL dual_store_keeps_rdata got=%0h exp=deadbeef", m_rdata); else passed++;
    step();
    mem_ack = 1'b0; mem_rdata = 32'h0;
    total++; if (s_rdata !== 32'h12345678 || stallM !== 1'b0) $display("FAIL dual_done got=%0h/%0h exp=12345678/0", s_rdata, stallM); else passed++;
    total++; if (stalls != 3) $display("FAIL dual_stall_cycles got=%0d exp=3", stalls); else passed++;
    // Requests and acks during DONE must not start an access.
    m_req = 1'b1; m_addr = 32'h30; mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    total++; if (mem_req !== 1'b0 || stallM !== 1'b1) $display("FAIL done_ignores_req got=%0h/%0h exp=0/1", mem_req, stallM); else passed++;
    m_req = 1'b0;
    step();
    total++; if (mem_req !== 1'b0 || stallM !== 1'b0) $display("FAIL done_back_idle got=%0h/%0h exp=0/0", mem_req, stallM); else passed++;
  endtask

  task automatic test_slave_wait();
    int reqs = 0;
    s_req = 1'b1; s_we = 1'b0; s_addr = 32'h40;
    step();
    s_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (mem_req === 1'b1 && mem_addr === 32'h40) reqs++;
      if (i == 3) begin mem_ack = 1'b1; mem_rdata = 32'hCAFEF00D; end
      step();
    end
    mem_ack = 1'b0; mem_rdata = 32'h0;
    total++; if (reqs != 4) $display("FAIL sw_req_cycles got=%0d exp=4", reqs); else passed++;
    total++; if (s_rdata !== 32'hCAFEF00D || m_rdata !== 32'hDEADBEEF) $display("FAIL sw_rdata got=%0h/%0h exp=cafef00d/deadbeef", s_rdata, m_rdata); else passed++;
    total++; if (mem_req !== 1'b0 || stallM !== 1'b0 || timeout !== 1'b0) $display("FAIL sw_done got=%0h/%0h/%0h exp=0/0/0", mem_req, stallM, timeout); else passed++;
    step();
  endtask

  task automatic test_timeout();
    int n = 0;
    m_req = 1'b1; m_we = 1'b0; m_addr = 32'h80;
    step();
    m_req = 1'b0;
    mem_rdata = 32'h77777777;
    while (mem_req === 1'b1 && n < 300) begin
      n++;
      step();
    end
    total++; if (n != 256) $display("FAIL to_req_cycles got=%0d exp=256", n); else passed++;
    total++; if (timeout !== 1'b1 || stallM !== 1'b0 || m_rdata !== 32'hDEADBEEF) $display("FAIL to_done got=%0h/%0h/%0h exp=1/0/deadbeef", timeout, stallM, m_rdata); else passed++;
    step();
    step();
    total++; if (timeout !== 1'b1 || mem_req !== 1'b0) $display("FAIL to_sticky got=%0h/%0h exp=1/0", timeout, mem_req); else passed++;
    mem_rdata = 32'h0;
  endtask

  task automatic test_reset_mid_access();
    s_req = 1'b1; s_we = 1'b0; s_addr = 32'h44;
    step();
    s_req = 1'b0;
    total++; if (mem_req !== 1'b1) $display("FAIL rm_sacc got=%0h exp=1", mem_req); else passed++;
    #2 rst = 1'b0;
    #1;
    total++; if (mem_req !== 1'b0 || mem_addr !== 32'h0 || stallM !== 1'b0) $display("FAIL rm_drop got=%0h/%0h/%0h exp=0/0/0", mem_req, mem_addr, stallM); else passed++;
    total++; if ({timeout, m_rdata, s_rdata} !== 65'd0) $display("FAIL rm_outputs got=%0h exp=0", {timeout, m_rdata, s_rdata}); else passed++;
    mem_ack = 1'b1; mem_rdata = 32'h99;
    @(negedge clk);
    rst = 1'b1;
    step();
    step();
    mem_ack = 1'b0; mem_rdata = 32'h0;
    total++; if (s_rdata !== 32'h0 || mem_req !== 1'b0 || stallM !== 1'b0) $display("FAIL rm_spurious_ack got=%0h/%0h/%0h exp=0/0/0", s_rdata, mem_req, stallM); else passed++;
  endtask

  initial begin
    test_reset();
    test_master_load();
    test_dual();
    test_slave_wait();
    test_timeout();
    test_reset_mid_access();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
